aes_subbytes_simd: RTL and testbench

AES_SUBBYTES_SIMD -- requirements
Module: aes_subbytes_simd

---
 rtl/aes_subbytes_simd.sv | 127 ++++++++++++
 tb/tb_aes_subbytes_simd.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_subbytes_simd.sv
// Two-stage, LANES-wide AES SubBytes pipeline with valid/ready flow control.
// Define AES_INV_SBOX_EN to add the inverse S-box, selected per word by in_inv.
module aes_subbytes_simd #(
    parameter int LANES = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*8-1:0]   in_data,
    input  logic                 in_inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*8-1:0]   out_data,
    output logic [CNT_W-1:0]     blk_cnt,
    output logic                 busy
);

    localparam logic [0:255][7:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef AES_INV_SBOX_EN
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    logic                s1_inv_q, s1_inv_d;
`else
    logic                unused_inv;
    assign unused_inv = in_inv;
`endif

    logic                s1_valid_q, s1_valid_d;
    logic [LANES*8-1:0]  s1_data_q, s1_data_d;
    logic                s2_valid_q, s2_valid_d;
    logic [LANES*8-1:0]  s2_data_q, s2_data_d;
    logic [CNT_W-1:0]    blk_cnt_q, blk_cnt_d;
    logic [LANES*8-1:0]  sub_data;
    logic                s1_adv, s2_adv;

    // Lanes are fully independent lookups on the S1 register.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] lane_byte;
        assign lane_byte = s1_data_q[8*gi +: 8];
`ifdef AES_INV_SBOX_EN
        assign sub_data[8*gi +: 8] = s1_inv_q ? INV_SBOX[lane_byte] : FWD_SBOX[lane_byte];
`else
        assign sub_data[8*gi +: 8] = FWD_SBOX[lane_byte];
`endif
    end

    assign s2_adv    = !s2_valid_q || out_ready;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign blk_cnt   = blk_cnt_q;
    assign busy      = s1_valid_q || s2_valid_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
`ifdef AES_INV_SBOX_EN
        s1_inv_d   = s1_inv_q;
`endif
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        blk_cnt_d  = blk_cnt_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
`ifdef AES_INV_SBOX_EN
                s1_inv_d  = in_inv;
`endif
            end
        end
        // Data registers only load on real words so out_data holds through bubbles.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = sub_data;
            end
        end
        if (s2_valid_q && out_ready) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
`ifdef AES_INV_SBOX_EN
            s1_inv_q   <= 1'b0;
`endif
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            blk_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
`ifdef AES_INV_SBOX_EN
            s1_inv_q   <= s1_inv_d;
`endif
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_subbytes_simd.sv
// Bench for aes_subbytes_simd (LANES=5, CNT_W=4); S-box model derived from GF(2^8) arithmetic.
module tb_aes_subbytes_simd;

    localparam int LANES = 5;
    localparam int CNT_W = 4;
    localparam int W     = LANES * 8;
`ifdef AES_INV_SBOX_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           in_inv = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   out_data;
    logic [CNT_W-1:0] blk_cnt;
    logic           busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] fwd_tbl [256];
    logic [7:0] inv_tbl [256];

    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] mcnt = '0;
    bit               armed = 1'b0;

    aes_subbytes_simd #(.LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .blk_cnt(blk_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv;
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            fwd_tbl[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[8*i +: 8] = (INV_EN && inv) ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] word(input int k);
        return {8'(k * 29 + 3), 8'(k * 53 + 17), 8'(k * 7 + 200), 8'(k * 113 + 91), 8'(k)};
    endfunction

    // Scoreboard: every accepted word must leave once, in order, as its substitution.
    always @(negedge clk) begin
        if (armed) begin
            chk("mon_blk_cnt", blk_cnt, mcnt);
            chk("mon_busy", busy, exp_q.size() != 0);
            if (out_valid && exp_q.size() == 0) chk("mon_spurious_out_valid", out_valid, 0);
        end
        if (!rst_n) begin
            exp_q.delete();
            mcnt = '0;
            armed = 1'b1;
        end else if (armed) begin
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("mon_out_data", out_data, exp_q.pop_front());
                mcnt = mcnt + 1'b1;
            end
            if (in_valid && in_ready) exp_q.push_back(model_word(in_data, in_inv));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            tick();
        end
        chk("drain_busy_timeout", busy, 0);
    endtask

    task automatic send_check(input string name, input logic [W-1:0] din, input logic inv,
                              input logic [W-1:0] exp);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = din;
        in_inv = inv;
        #1;
        chk({name, "_accept"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        #1;
        chk({name, "_valid_at_1"}, out_valid, 0);
        tick();
        chk({name, "_valid_at_2"}, out_valid, 1);
        chk({name, "_data"}, out_data, exp);
    endtask

    initial begin
        int k, accepts;
        build_tables();
        chk("model_pin_fwd_53", fwd_tbl[8'h53], 8'hed);
        chk("model_pin_fwd_00", fwd_tbl[8'h00], 8'h63);
        chk("model_pin_inv_00", inv_tbl[8'h00], 8'h52);
        chk("model_pin_inv_fb", inv_tbl[8'hfb], 8'h63);

        tick();
        do_reset();

        send_check("fwd5", 40'hf1_c9_64_9a_3e, 1'b0, 40'ha1_dd_43_b8_b2);
        send_check("fwd63", 40'h63_00_63_00_63, 1'b0, 40'hfb_63_fb_63_fb);
        send_check("inv63", 40'h63_00_63_00_63, 1'b1,
                   INV_EN ? 40'h00_52_00_52_00 : 40'hfb_63_fb_63_fb);
        drain();

        // Mixed-mode consecutive words.
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data = word(50 + c);
            in_inv = c[0];
            tick();
        end
        drain();

        // Backpressure: only two words fit while out_ready is low.
        do_reset();
        out_ready = 1'b0;
        in_inv = 1'b0;
        k = 0;
        accepts = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data = word(100 + k);
            #1;
            if (in_ready) begin accepts++; k++; end
            tick();
        end
        chk("bp_accepts", accepts, 2);
        in_data = word(100 + k);
        #1;
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_out_data_held", out_data, model_word(word(100), 1'b0));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 4; c++) begin
            in_valid = 1'b1;
            in_data = word(100 + k);
            #1;
            if (in_ready) k++;
            tick();
        end
        chk("bp_all_sent", k, 4);
        drain();
        chk("bp_blk_cnt", blk_cnt, 4);

        // Throughput: 10 back-to-back words.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 10);
            in_data = word(c);
            #1;
            chk($sformatf("tp_out_valid_c%0d", c), out_valid, (c >= 2 && c <= 11));
            if (c < 10) chk($sformatf("tp_in_ready_c%0d", c), in_ready, 1);
            tick();
        end
        chk("tp_blk_cnt", blk_cnt, 10);

        // Patterned backpressure.
        do_reset();
        k = 0;
        for (int c = 0; c < 40 && k < 12; c++) begin
            out_ready = (c % 3 != 0);
            in_valid = 1'b1;
            in_data = word(300 + k);
            in_inv = k[1];
            #1;
            if (in_ready) k++;
            tick();
        end
        chk("pbp_all_sent", k, 12);
        drain();
        chk("pbp_blk_cnt", blk_cnt, 12);

        // Reset with two words in flight.
        do_reset();
        out_ready = 1'b1;
        in_inv = 1'b0;
        in_valid = 1'b1;
        in_data = word(200);
        tick();
        in_data = word(201);
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_in_flight", out_valid, 1);
        tick();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_blk_cnt", blk_cnt, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_out_data", out_data, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("mrst_no_ghost_c%0d", c), out_valid, 0);
            tick();
        end

        // Counter wrap: 17 transfers on a 4-bit counter.
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            in_valid = 1'b1;
            in_data = word(400 + c);
            #1;
            chk($sformatf("wrap_in_ready_c%0d", c), in_ready, 1);
            tick();
        end
        drain();
        chk("wrap_blk_cnt", blk_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
